// File: rtl/sw_result_collector.sv
// Per-query summary builder for the SmithWaterman result stream: tracks best/second/hits,
// cross-checks the core's reported maximum, and queues records in a small FWFT FIFO.
module sw_result_collector #(
    parameter int CALC_BIT      = 16,
    parameter int MAX_T_NUM_BIT = 8,
    parameter int Q_IDX_BIT     = 8,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_i,
    input  logic [CALC_BIT-1:0]      result_i,
    input  logic                     change_q_i,
    input  logic [MAX_T_NUM_BIT-1:0] match_idx_i,
    input  logic [CALC_BIT-1:0]      max_result_i,
    input  logic [CALC_BIT-1:0]      threshold_i,
    output logic                     rec_valid_o,
    input  logic                     rec_ready_i,
    output logic [Q_IDX_BIT-1:0]     rec_q_idx_o,
    output logic [MAX_T_NUM_BIT-1:0] rec_best_idx_o,
    output logic [CALC_BIT-1:0]      rec_best_o,
    output logic [CALC_BIT-1:0]      rec_second_o,
    output logic [MAX_T_NUM_BIT-1:0] rec_hits_o,
    output logic [MAX_T_NUM_BIT-1:0] rec_t_cnt_o,
    output logic                     rec_err_o,
    output logic                     overflow_o,
    output logic                     err_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int REC_W = Q_IDX_BIT + 3 * MAX_T_NUM_BIT + 2 * CALC_BIT + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    // ---------------- per-query accumulators ----------------
    logic [CALC_BIT-1:0]      best_reg, best_next;
    logic [CALC_BIT-1:0]      second_reg, second_next;
    logic [MAX_T_NUM_BIT-1:0] best_idx_reg, best_idx_next;
    logic [MAX_T_NUM_BIT-1:0] hits_reg, hits_next;
    logic [MAX_T_NUM_BIT-1:0] t_idx_reg;
    logic [Q_IDX_BIT-1:0]     q_idx_reg;

    logic finalize;
    assign finalize = valid_i & change_q_i;

    // Accumulator values including the current target; ties keep the earlier
    // target as best and a score equal to best never becomes second.
    always_comb begin
        best_next     = best_reg;
        second_next   = second_reg;
        best_idx_next = best_idx_reg;
        hits_next     = hits_reg;
        if (valid_i) begin
            if (result_i > best_reg) begin
                second_next   = best_reg;
                best_next     = result_i;
                best_idx_next = t_idx_reg;
            end else if ((result_i > second_reg) && (result_i != best_reg)) begin
                second_next = result_i;
            end
            if ((result_i >= threshold_i) && !(&hits_reg)) begin
                hits_next = hits_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            best_reg     <= '0;
            second_reg   <= '0;
            best_idx_reg <= '0;
            hits_reg     <= '0;
            t_idx_reg    <= '0;
            q_idx_reg    <= '0;
        end else if (finalize) begin
            best_reg     <= '0;
            second_reg   <= '0;
            best_idx_reg <= '0;
            hits_reg     <= '0;
            t_idx_reg    <= '0;
            q_idx_reg    <= q_idx_reg + 1'b1;
        end else if (valid_i) begin
            best_reg     <= best_next;
            second_reg   <= second_next;
            best_idx_reg <= best_idx_next;
            hits_reg     <= hits_next;
            t_idx_reg    <= t_idx_reg + 1'b1;
        end
    end

    // ---------------- record formation ----------------
    logic [MAX_T_NUM_BIT-1:0] t_cnt;
    logic                     rec_err_in;
    logic [REC_W-1:0]         rec_in;

    assign t_cnt      = t_idx_reg + 1'b1;
    assign rec_err_in = (best_next != max_result_i) || (best_idx_next != match_idx_i);
    assign rec_in     = {q_idx_reg, best_idx_next, best_next, second_next,
                         hits_next, t_cnt, rec_err_in};

    // ---------------- FWFT record FIFO ----------------
    logic [REC_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             full, not_empty, push, pop;
    logic             overflow_reg, err_reg;

    assign not_empty = (count_reg != '0);
    assign full      = (count_reg == DEPTH_CNT);
    assign pop       = not_empty & rec_ready_i;
    assign push      = finalize & (~full | pop);

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr_reg] <= rec_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Sticky status; a dropped record never contributes to err.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_reg <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            if (finalize && !push) overflow_reg <= 1'b1;
            if (push && rec_err_in) err_reg <= 1'b1;
        end
    end

    // Head is masked so that an empty FIFO presents all-zero record fields.
    logic [REC_W-1:0] rec_out;
    assign rec_out     = not_empty ? mem[rd_ptr_reg] : '0;
    assign rec_valid_o = not_empty;
    assign {rec_q_idx_o, rec_best_idx_o, rec_best_o, rec_second_o,
            rec_hits_o, rec_t_cnt_o, rec_err_o} = rec_out;
    assign overflow_o  = overflow_reg;
    assign err_o       = err_reg;

endmodule
